mmio_responder: RTL and testbench
=================================

# mmio_responder

Memory-mapped I/O responder for the RISC231-M1 single-cycle processor: it answers the datapath's load/store port for the I/O window, and it drives the controller's `enable` input to freeze the processor while an access cannot finish in one cycle. It holds an LED register, a free-running timer, a slow scratch register behind configurable wait states, and a byte FIFO feeding a valid/ready character sink. Addresses outside the window get no response, and the datapath's data-memory mux handles them.

## Interface
- `WAIT_STATES`, 2: stall cycles for a slow-register access; legal range 1..15.
- `FIFO_DEPTH`, 4: character FIFO entries; must be a power of two, at least 2.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_addr` in 32: byte address from the ALU result.
- `mem_wd` in 32: store data.
- `mem_write` in 1: store intent, ungated. It must not depend on `enable`.
- `mem_read` in 1: load intent (lw), ungated.
- `mem_rdata` out 32: load data, combinational.
- `io_sel` out 1: high when `mem_addr[31:8] == 24'h100000`; selects `mem_rdata` in the writeback mux.
- `enable` out 1: processor run enable. 0 freezes PC, register-file writes and memory writes.
- `led` out 16: LED register.
- `char_data` out 8: FIFO head byte.
- `char_valid` out 1: FIFO not empty.
- `char_ready` in 1: the sink accepts the byte when `char_valid && char_ready`.

## Operation
- Address map, decoded on `mem_addr[7:0]`:
  - 0x00 LED, R/W. Reads return the 16-bit value zero-extended; writes take `wd[15:0]`.
  - 0x04 TIMER, R/W. Reads return the count; any write clears it to 0 and the data is ignored.
  - 0x08 CHAR_TX, write-only. A write pushes `wd[7:0]`; a read returns 0.
  - 0x0C STATUS, read-only. bit0 = empty, bit1 = full, bits[5:2] = occupancy, other bits 0.
  - 0x10 SLOW, 32-bit R/W, always accessed with a stall.
  - Any other offset reads 0 and ignores writes.
- When both `mem_read` and `mem_write` are high, the access is treated as a write and `mem_rdata` = 0.
- Timer: increments every cycle, including stalled cycles, and wraps from 2^32−1 to 0. A clearing write wins over the increment.
- Fast accesses (every register except SLOW, and CHAR_TX when the FIFO is not full):
  - `enable` = 1.
  - Read data is valid in the same cycle.
  - Writes commit at the next rising edge.
- Stall FSM, states IDLE, WAIT, DONE:
  - IDLE → WAIT on a SLOW access. In that cycle `enable` = 0, the operation and write data are latched, and the counter loads `WAIT_STATES`−1.
  - WAIT: `enable` = 0 and the counter decrements; at counter = 0 the FSM goes to DONE.
  - DONE: `enable` = 1 and `mem_rdata` = SLOW. A latched write commits at the edge leaving DONE; the FSM returns to IDLE.
  - Inputs are ignored in WAIT and DONE, so there is no retrigger.
- CHAR_TX write with the FIFO full:
  - `enable` = 0 combinationally and the FSM stays in IDLE.
  - The write is retried every cycle; it completes in the first cycle that shows not-full.
  - A pop in a full cycle does not admit a push in that same cycle.
- FIFO:
  - A pop occurs when `char_valid && char_ready`.
  - A simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `io_sel` = 0: `enable` = 1, `mem_rdata` = 0, no state change.

## Timing
- Reset values:
  - FSM = IDLE, `led` = 0, timer = 0, SLOW = 0, FIFO empty.
  - `char_valid` = 0, `char_data` = 0, `enable` = 1, `mem_rdata` = 0.
- Fast-access latency is 0 cycles, so the processor sees no stall.
- A SLOW access holds `enable` low for `WAIT_STATES`+1 cycles and completes in cycle `WAIT_STATES`+2.
- A FIFO byte is visible on `char_data` the cycle after its push edge.
- Reset asserted mid-stall aborts the pending SLOW write (it never commits), discards FIFO contents, and returns `enable` to 1 immediately.

## Structure
- Package `mmio_pkg` holds:
  - the base address 32'h1000_0000 and the five offset constants;
  - the enum `stall_state_t` {IDLE, WAIT, DONE};
  - the STATUS bit-position constants.
- Sub-module `char_fifo`: parameterized synchronous FIFO with push/pop/full/empty/count and asynchronous active-low reset.
- Top level contains the address decode, registers, timer, FSM and read mux.

## Test plan
- After reset: write 0x0000_ABCD to 0x1000_0000. → `led` = 0xABCD on the next edge; a read of the same address returns 0x0000_ABCD with `enable` = 1 throughout.
- Read TIMER 10 cycles after reset release → 10. Write 0x1234 to TIMER → a read one cycle later returns 1.
- With `WAIT_STATES` = 2, write 0xDEADBEEF to 0x1000_0010, then read it back.
  - For each access, `enable` is low for exactly 3 cycles and high in the 4th.
  - The read returns 0xDEADBEEF.
- With `char_ready` = 0, push 5 bytes 0x41..0x45 at `FIFO_DEPTH` = 4.
  - The 5th push stalls (`enable` = 0) and STATUS = 0x12.
  - Raise `char_ready` for one cycle → 0x41 pops, the stall ends the next cycle, and 0x45 is enqueued.
- Assert `reset_n` during WAIT of a SLOW write of 0x5555_5555 → a later SLOW read returns 0 and `enable` is 1 during reset.
- Access 0x2000_0000 with both `mem_read` and `mem_write` high → `io_sel` = 0, `mem_rdata` = 0, `enable` = 1, and no register changes.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the RISC231-M1 I/O responder.
//   - I/O window base address and the register offsets inside it
//   - stall FSM state type
//   - STATUS register bit positions
package mmio_pkg;

   localparam logic [31:0] MMIO_BASE = 32'h1000_0000;

   localparam logic [7:0] OFF_LED     = 8'h00;
   localparam logic [7:0] OFF_TIMER   = 8'h04;
   localparam logic [7:0] OFF_CHAR_TX = 8'h08;
   localparam logic [7:0] OFF_STATUS  = 8'h0C;
   localparam logic [7:0] OFF_SLOW    = 8'h10;

   localparam int STATUS_EMPTY_BIT = 0;
   localparam int STATUS_FULL_BIT  = 1;
   localparam int STATUS_COUNT_LSB = 2;
   localparam int STATUS_COUNT_MSB = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } stall_state_t;

endpackage

// File: rtl/char_fifo.sv
// char_fifo: synchronous FIFO with power-of-two depth.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_push, i_data     enqueue request and data (ignored when full)
//   i_pop              dequeue request (ignored when empty)
//   o_data             head entry, 0 while empty
//   o_full, o_empty    occupancy flags
//   o_count            number of stored entries (0..DEPTH)
module char_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Masking the head while empty keeps the output defined without resetting storage.
   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Power-of-two depth lets the pointers wrap by plain overflow.
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by the pointers
   // and count, so clearing the array would only cost flops and reset routing.
   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: I/O-window responder on the RISC231-M1 load/store port.
// Holds an LED register, a free-running timer, a slow scratch register behind
// WAIT_STATES stall cycles, and a byte FIFO draining into a valid/ready sink.
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   mem_addr, mem_wd        byte address and store data from the datapath
//   mem_write, mem_read     ungated store/load intent
//   mem_rdata               combinational load data (0 outside the window)
//   io_sel                  address falls in the I/O window
//   enable                  processor run enable; low freezes the processor
//   led                     LED register
//   char_data, char_valid   FIFO head byte and not-empty flag
//   char_ready              sink accepts the head byte when valid is high
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int WAIT_STATES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wd,
   input  logic        mem_write,
   input  logic        mem_read,
   output logic [31:0] mem_rdata,
   output logic        io_sel,
   output logic        enable,
   output logic [15:0] led,
   output logic [7:0]  char_data,
   output logic        char_valid,
   input  logic        char_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   stall_state_t     r_state;
   stall_state_t     w_state_next;
   logic [3:0]       r_wait_cnt;
   logic [3:0]       w_wait_cnt_next;
   logic             r_slow_we;
   logic [31:0]      r_slow_wd;
   logic [31:0]      r_slow;
   logic [15:0]      r_led;
   logic [31:0]      r_timer;

   logic             w_io_sel;
   logic [7:0]       w_offset;
   logic             w_wr;
   logic             w_rd;
   logic             w_idle;
   logic             w_slow_start;
   logic             w_tx_req;
   logic             w_push;
   logic             w_pop;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CNT_W-1:0] w_fifo_count;
   logic [7:0]       w_fifo_data;
   logic [31:0]      w_status;
   logic [31:0]      w_rdata;
   logic             w_enable;

   // ---------------- decode ----------------
   assign w_io_sel = (mem_addr[31:8] == MMIO_BASE[31:8]);
   assign w_offset = mem_addr[7:0];
   // A simultaneous read and write is a write.
   assign w_wr     = w_io_sel & mem_write;
   assign w_rd     = w_io_sel & mem_read & ~mem_write;
   // New accesses are only taken in IDLE; WAIT and DONE ignore the port.
   assign w_idle       = (r_state == IDLE);
   assign w_slow_start = w_idle & (w_wr | w_rd) & (w_offset == OFF_SLOW);
   assign w_tx_req     = w_idle & w_wr & (w_offset == OFF_CHAR_TX);
   // Fullness is the registered flag, so a pop in a full cycle frees room
   // only for the following cycle's retry.
   assign w_push       = w_tx_req & ~w_fifo_full;
   assign w_pop        = ~w_fifo_empty & char_ready;

   // ---------------- stall FSM ----------------
   // NOTE: every combinational output gets a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_enable        = 1'b1;
      case (r_state)
         IDLE: begin
            if (w_slow_start) begin
               w_state_next    = WAIT;
               w_wait_cnt_next = 4'(WAIT_STATES - 1);
               w_enable        = 1'b0;
            end else if (w_tx_req && w_fifo_full) begin
               // Processor holds the store until the FIFO has room.
               w_enable = 1'b0;
            end
         end
         WAIT: begin
            w_enable = 1'b0;
            if (r_wait_cnt == 4'd0) w_state_next = DONE;
            else                    w_wait_cnt_next = r_wait_cnt - 4'd1;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
         r_slow_we  <= 1'b0;
         r_slow_wd  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         if (w_slow_start) begin
            r_slow_we <= w_wr;
            r_slow_wd <= mem_wd;
         end
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_led   <= '0;
         r_timer <= '0;
         r_slow  <= '0;
      end else begin
         if (w_idle && w_wr && (w_offset == OFF_LED)) r_led <= mem_wd[15:0];
         // A clearing write beats the increment; the count runs through stalls.
         if (w_idle && w_wr && (w_offset == OFF_TIMER)) r_timer <= '0;
         else                                           r_timer <= r_timer + 32'd1;
         // The latched SLOW write lands on the edge that leaves DONE.
         if ((r_state == DONE) && r_slow_we) r_slow <= r_slow_wd;
      end
   end

   // ---------------- character FIFO ----------------
   char_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_char_fifo (
      .i_clk   (clock),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_data  (mem_wd[7:0]),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_comb begin
      w_status                                    = '0;
      w_status[STATUS_EMPTY_BIT]                  = w_fifo_empty;
      w_status[STATUS_FULL_BIT]                   = w_fifo_full;
      w_status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 4'(w_fifo_count);
   end

   // ---------------- read mux ----------------
   always_comb begin
      w_rdata = '0;
      if (r_state == DONE) begin
         w_rdata = r_slow;
      end else if (w_idle && w_rd) begin
         case (w_offset)
            OFF_LED:    w_rdata = {16'h0000, r_led};
            OFF_TIMER:  w_rdata = r_timer;
            OFF_STATUS: w_rdata = w_status;
            default:    w_rdata = '0;
         endcase
      end
   end

   // During reset the port may still present a SLOW or STATUS access; the
   // outputs are forced to their idle values so the processor is never frozen.
   assign mem_rdata  = reset_n ? w_rdata : 32'h0;
   assign enable     = w_enable | ~reset_n;
   assign io_sel     = w_io_sel;
   assign led        = r_led;
   assign char_data  = w_fifo_data;
   assign char_valid = ~w_fifo_empty;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed plus randomized checks of mmio_responder against
// a transaction-level model (register variables, a byte queue and a stall budget).
module tb_mmio_responder;

   localparam int WS    = 2;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_rdata;
   logic        io_sel;
   logic        enable;
   logic [15:0] led;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;

   always #5 clock = ~clock;

   mmio_responder #(
      .WAIT_STATES (WS),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_rdata  (mem_rdata),
      .io_sel     (io_sel),
      .enable     (enable),
      .led        (led),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state.
   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_slow;
   logic [7:0]  m_q[$];
   int          m_stall_left = -1;
   bit          rand_ready   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_led        = '0;
      m_timer      = '0;
      m_slow       = '0;
      m_q.delete();
      m_stall_left = -1;
   endtask

   function automatic logic [31:0] model_status();
      int n;
      n = m_q.size();
      return {26'd0, 4'(n), (n == DEPTH), (n == 0)};
   endfunction

   // One processor cycle: inputs are already driven (just after an edge),
   // outputs are compared mid-cycle, then the model absorbs the edge.
   task automatic one_cycle(output bit done, output bit dut_en, output logic [31:0] rd_seen);
      bit          sel, wr, rd, slow, exp_en, pop;
      logic [7:0]  off;
      logic [31:0] exp_rd;
      if (rand_ready) char_ready = 1'($urandom_range(0, 1));
      #4;
      sel  = (mem_addr[31:8] == 24'h100000);
      off  = mem_addr[7:0];
      wr   = sel && mem_write;
      rd   = sel && mem_read && !mem_write;
      slow = sel && (mem_read || mem_write) && (off == 8'h10);
      if (slow) begin
         if (m_stall_left < 0) m_stall_left = WS + 1;
         exp_en = (m_stall_left == 0);
      end else begin
         exp_en = !(wr && off == 8'h08 && m_q.size() == DEPTH);
      end
      chk("io_sel", 32'(io_sel), 32'(sel));
      chk("enable", 32'(enable), 32'(exp_en));
      if (exp_en) begin
         if (slow)     exp_rd = m_slow;
         else if (!rd) exp_rd = '0;
         else begin
            case (off)
               8'h00:   exp_rd = {16'h0, m_led};
               8'h04:   exp_rd = m_timer;
               8'h0C:   exp_rd = model_status();
               default: exp_rd = '0;
            endcase
         end
         chk("rdata", mem_rdata, exp_rd);
      end
      chk("led", 32'(led), 32'(m_led));
      chk("char_valid", 32'(char_valid), 32'(m_q.size() > 0));
      chk("char_data", 32'(char_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
      dut_en  = enable;
      rd_seen = mem_rdata;
      pop     = char_ready && (m_q.size() > 0);
      @(posedge clock);
      #1;
      if (exp_en && wr) begin
         if (off == 8'h00) m_led  = mem_wd[15:0];
         if (off == 8'h10) m_slow = mem_wd;
      end
      if (exp_en && wr && off == 8'h04) m_timer = '0;
      else                              m_timer = m_timer + 32'd1;
      if (pop) void'(m_q.pop_front());
      if (exp_en && wr && off == 8'h08) m_q.push_back(mem_wd[7:0]);
      if (slow) m_stall_left = exp_en ? -1 : m_stall_left - 1;
      done = exp_en;
   endtask

   // Holds one access on the port until it completes or max_cyc cycles pass.
   task automatic access(input logic [31:0] addr, input logic [31:0] wd, input bit rd, input bit wr,
                         input int max_cyc, output bit done, output int stalls,
                         output logic [31:0] rdata);
      bit dut_en;
      done      = 1'b0;
      stalls    = 0;
      rdata     = '0;
      mem_addr  = addr;
      mem_wd    = wd;
      mem_read  = rd;
      mem_write = wr;
      for (int i = 0; i < max_cyc && !done; i++) begin
         one_cycle(done, dut_en, rdata);
         if (!dut_en) stalls++;
      end
   endtask

   task automatic idle(input int n);
      bit          done, dut_en;
      logic [31:0] r;
      mem_addr  = '0;
      mem_wd    = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      for (int i = 0; i < n; i++) one_cycle(done, dut_en, r);
   endtask

   initial begin
      bit          done;
      int          stalls;
      logic [31:0] rdata;
      logic [7:0]  offs [7];

      offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h1C};

      // Reset with a SLOW read already on the port.
      reset_n    = 1'b0;
      char_ready = 1'b0;
      mem_addr   = 32'h1000_0010;
      mem_wd     = '0;
      mem_read   = 1'b1;
      mem_write  = 1'b0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("rst_enable", 32'(enable), 32'h1);
      chk("rst_rdata", mem_rdata, 32'h0);
      chk("rst_valid", 32'(char_valid), 32'h0);
      chk("rst_char_data", 32'(char_data), 32'h0);
      chk("rst_led", 32'(led), 32'h0);
      mem_read = 1'b0;
      mem_addr = '0;
      reset_n  = 1'b1;
      model_reset();

      // Timer ten cycles after release, then clear-and-count.
      idle(10);
      access(32'h1000_0004, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);
      chk("timer_10", rdata, 32'd10);

      // LED write and read-back, no stall either way.
      access(32'h1000_0000, 32'h0000_ABCD, 1'b0, 1'b1, 1, done, stalls, rdata);
      chk("led_wr_stalls", 32'(stalls), 32'h0);
      access(32'h1000_0000, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);
      chk("led_value", 32'(led), 32'h0000_ABCD);
      chk("led_read", rdata, 32'h0000_ABCD);
      chk("led_rd_stalls", 32'(stalls), 32'h0);

      access(32'h1000_0004, 32'h0000_1234, 1'b0, 1'b1, 1, done, stalls, rdata);
      idle(1);
      access(32'h1000_0004, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);
      chk("timer_after_clear", rdata, 32'd1);

      // SLOW write then read: WS+1 stalled cycles each, data returned in DONE.
      access(32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 10, done, stalls, rdata);
      chk("slow_wr_done", 32'(done), 32'h1);
      chk("slow_wr_stalls", 32'(stalls), 32'd3);
      access(32'h1000_0010, 32'h0, 1'b1, 1'b0, 10, done, stalls, rdata);
      chk("slow_rd_stalls", 32'(stalls), 32'd3);
      chk("slow_rd_data", rdata, 32'hDEAD_BEEF);

      // Fill the FIFO with the sink stalled.
      for (int i = 0; i < 4; i++) begin
         access(32'h1000_0008, 32'h41 + 32'(i), 1'b0, 1'b1, 1, done, stalls, rdata);
         chk("push_stalls", 32'(stalls), 32'h0);
      end
      access(32'h1000_000C, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);
      chk("status_full", rdata, 32'h12);
      access(32'h1000_0008, 32'h45, 1'b0, 1'b1, 3, done, stalls, rdata);
      chk("push5_blocked", 32'(done), 32'h0);
      chk("push5_stalls", 32'(stalls), 32'd3);
      char_ready = 1'b1;
      access(32'h1000_0008, 32'h45, 1'b0, 1'b1, 1, done, stalls, rdata);
      chk("pop_cycle_still_stalled", 32'(stalls), 32'h1);
      char_ready = 1'b0;
      access(32'h1000_0008, 32'h45, 1'b0, 1'b1, 1, done, stalls, rdata);
      chk("push5_done", 32'(done), 32'h1);
      chk("push5_no_stall", 32'(stalls), 32'h0);
      access(32'h1000_000C, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);
      chk("status_refull", rdata, 32'h12);
      chk("head_after_pop", 32'(char_data), 32'h42);

      // Reset in the middle of a SLOW write: nothing commits, FIFO is emptied.
      access(32'h1000_0010, 32'h5555_5555, 1'b0, 1'b1, 2, done, stalls, rdata);
      chk("slow_pending", 32'(done), 32'h0);
      reset_n = 1'b0;
      #2;
      chk("midrst_enable", 32'(enable), 32'h1);
      chk("midrst_rdata", mem_rdata, 32'h0);
      chk("midrst_valid", 32'(char_valid), 32'h0);
      @(posedge clock);
      #1;
      mem_write = 1'b0;
      mem_addr  = '0;
      reset_n   = 1'b1;
      model_reset();
      access(32'h1000_0010, 32'h0, 1'b1, 1'b0, 10, done, stalls, rdata);
      chk("slow_after_rst", rdata, 32'h0);
      chk("slow_after_rst_stalls", 32'(stalls), 32'd3);

      // Outside the window: read+write at offsets that alias LED and TIMER.
      access(32'h1000_0000, 32'h0000_1357, 1'b0, 1'b1, 1, done, stalls, rdata);
      access(32'h2000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, done, stalls, rdata);
      chk("oow_rdata", rdata, 32'h0);
      chk("oow_stalls", 32'(stalls), 32'h0);
      access(32'h2000_0004, 32'hFFFF_FFFF, 1'b1, 1'b1, 1, done, stalls, rdata);
      idle(1);
      chk("oow_led_kept", 32'(led), 32'h0000_1357);
      access(32'h1000_0004, 32'h0, 1'b1, 1'b0, 1, done, stalls, rdata);

      // Randomized traffic with a randomly ready sink.
      rand_ready = 1'b1;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] addr;
         int          r;
         r = int'($urandom_range(0, 9));
         if (r == 0)      addr = 32'h2000_0000 | 32'(offs[$urandom_range(0, 6)]);
         else if (r == 1) addr = 32'h1000_0100 | 32'(offs[$urandom_range(0, 6)]);
         else             addr = 32'h1000_0000 | 32'(offs[$urandom_range(0, 6)]);
         access(addr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                64, done, stalls, rdata);
         if (!done) chk("rand_completion", 32'h0, 32'h1);
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      rand_ready = 1'b0;
      char_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
